uart_rx_core: RTL and testbench

- UART receiver (8N1, LSB first) that sits directly upstream of the AXI-Lite UART slave.
- Converts the UART_RX line into parallel bytes, a one-cycle RX_DONE strobe and a one-cycle framing-error strobe.
- Baud rate is a runtime value in baud units, driven from the slave's baud register. The oversampling divisor is derived internally by a serial divider.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_div.sv | 66 ++++++
 rtl/uart_rx_core.sv | 177 +++++++++++++++++
 tb/tb_uart_rx_core.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared types and constants for the UART receive path.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int DIV_W          = 32;
  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_baud_div.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_div
// Brief    : Restoring divider, one quotient bit per cycle; start restarts it.
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_div
  import uart_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DIV_W-1:0]   dividend,
  input  logic [DIV_W+3:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [DIV_W-1:0]   quotient
);

  localparam int c_cnt_w = $clog2(DIV_W);

  logic [DIV_W+4:0]   r_rem;
  logic [DIV_W+3:0]   r_dvs;
  logic [DIV_W-1:0]   r_q;
  logic [c_cnt_w-1:0] r_cnt;

  logic [DIV_W+4:0]   w_shift;
  logic [DIV_W+4:0]   w_diff;
  logic               w_ge;

  // r_q doubles as the dividend shift-out and the quotient shift-in register
  assign w_shift  = {r_rem[DIV_W+3:0], r_q[DIV_W-1]};
  assign w_ge     = (w_shift >= {1'b0, r_dvs});
  assign w_diff   = w_shift - {1'b0, r_dvs};
  assign quotient = r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem <= '0;
      r_dvs <= '0;
      r_q   <= '0;
      r_cnt <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        r_rem <= '0;
        r_dvs <= divisor;
        r_q   <= dividend;
        r_cnt <= '0;
        busy  <= 1'b1;
      end else if (busy) begin
        r_rem <= w_ge ? w_diff : w_shift;
        r_q   <= {r_q[DIV_W-2:0], w_ge};
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == c_cnt_w'(DIV_W - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_core
// Brief    : 8N1 UART receiver with runtime baud rate and internal divisor.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [31:0]           BAUD_RATE,
  input  logic                  UART_RX,
  output logic [DATA_WIDTH-1:0] RX_DATA,
  output logic                  RX_DONE,
  output logic                  RX_FRAME_ERR,
  output logic                  RX_BUSY,
  output logic                  DIV_VALID
);

  localparam int               c_os_log2  = $clog2(OVERSAMPLE);
  localparam int               c_idx_w    = $clog2(DATA_WIDTH);
  localparam logic [DIV_W-1:0] c_dividend = DIV_W'(CLK_FREQ);
  localparam logic [c_os_log2-1:0] c_half = c_os_log2'(OVERSAMPLE / 2 - 1);
  localparam logic [c_os_log2-1:0] c_full = c_os_log2'(OVERSAMPLE - 1);
  localparam logic [c_idx_w-1:0]   c_last = c_idx_w'(DATA_WIDTH - 1);

  logic [1:0]            r_sync;
  logic [31:0]           r_baud;
  logic [DIV_W-1:0]      r_div;
  logic [DIV_W-1:0]      r_tick_cnt;
  rx_state_t             r_state;
  logic [c_os_log2-1:0]  r_samp;
  logic [c_idx_w-1:0]    r_idx;
  logic [DATA_WIDTH-1:0] r_shift;

  logic                  w_rx_s;
  logic                  w_baud_chg;
  logic                  w_div_start;
  logic                  w_div_busy;
  logic                  w_div_done;
  logic [DIV_W-1:0]      w_quot;
  logic [DIV_W+3:0]      w_scaled;
  logic                  w_tick;
  logic                  w_start_det;

  // ---------------------------------------------------------------- sync
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_sync <= 2'b11;
    else        r_sync <= {r_sync[0], UART_RX};
  end
  assign w_rx_s = r_sync[1];

  // ------------------------------------------------------- divisor setup
  assign w_baud_chg  = (BAUD_RATE != r_baud);
  assign w_div_start = w_baud_chg && (BAUD_RATE != 32'd0);
  assign w_scaled    = {4'b0000, BAUD_RATE} << c_os_log2;

  uart_baud_div u_div (
    .clk      (ACLK),
    .rst      (ARESET),
    .start    (w_div_start),
    .dividend (c_dividend),
    .divisor  (w_scaled),
    .busy     (w_div_busy),
    .done     (w_div_done),
    .quotient (w_quot)
  );

  // A zero baud never enables the receiver, even if a stale result completes
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_baud    <= '0;
      r_div     <= DIV_W'(1);
      DIV_VALID <= 1'b0;
    end else if (w_baud_chg) begin
      r_baud    <= BAUD_RATE;
      DIV_VALID <= 1'b0;
    end else if (w_div_done && !w_div_busy && (r_baud != 32'd0)) begin
      r_div     <= (w_quot == '0) ? DIV_W'(1) : w_quot;
      DIV_VALID <= 1'b1;
    end
  end

  // -------------------------------------------------------- tick counter
  assign w_start_det = (r_state == IDLE) && !w_rx_s && DIV_VALID;
  assign w_tick      = DIV_VALID && (r_tick_cnt == r_div - 1'b1);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)                                   r_tick_cnt <= '0;
    else if (!DIV_VALID || w_start_det || w_tick) r_tick_cnt <= '0;
    else                                          r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  // ----------------------------------------------------------------- FSM
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state      <= IDLE;
      r_samp       <= '0;
      r_idx        <= '0;
      r_shift      <= '0;
      RX_DATA      <= '0;
      RX_DONE      <= 1'b0;
      RX_FRAME_ERR <= 1'b0;
    end else begin
      RX_DONE      <= 1'b0;
      RX_FRAME_ERR <= 1'b0;
      if (!DIV_VALID) begin
        r_state <= IDLE;
        r_samp  <= '0;
        r_idx   <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (!w_rx_s) begin
              r_state <= START;
              r_samp  <= '0;
              r_idx   <= '0;
            end
          end
          START: begin
            if (w_tick) begin
              if (r_samp == c_half) begin
                r_samp  <= '0;
                r_state <= w_rx_s ? IDLE : DATA;
              end else begin
                r_samp <= r_samp + 1'b1;
              end
            end
          end
          DATA: begin
            if (w_tick) begin
              if (r_samp == c_full) begin
                r_samp  <= '0;
                r_shift <= {w_rx_s, r_shift[DATA_WIDTH-1:1]};
                if (r_idx == c_last) r_state <= STOP;
                else                 r_idx   <= r_idx + 1'b1;
              end else begin
                r_samp <= r_samp + 1'b1;
              end
            end
          end
          STOP: begin
            if (w_tick) begin
              if (r_samp == c_full) begin
                r_samp <= '0;
                if (w_rx_s) begin
                  RX_DATA <= r_shift;
                  RX_DONE <= 1'b1;
                  r_state <= IDLE;
                end else begin
                  // Hold off until the line recovers so a break is not a new start
                  RX_FRAME_ERR <= 1'b1;
                  r_state      <= WAIT_HIGH;
                end
              end else begin
                r_samp <= r_samp + 1'b1;
              end
            end
          end
          WAIT_HIGH: begin
            if (w_rx_s) r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign RX_BUSY = (r_state == START) || (r_state == DATA) || (r_state == STOP);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_core
// Brief    : Scoreboard bench for uart_rx_core with directed frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_core;

  logic        ACLK      = 1'b0;
  logic        ARESET    = 1'b1;
  logic [31:0] BAUD_RATE = 32'd9600;
  logic        UART_RX   = 1'b1;
  logic [7:0]  RX_DATA;
  logic        RX_DONE;
  logic        RX_FRAME_ERR;
  logic        RX_BUSY;
  logic        DIV_VALID;

  uart_rx_core #(
    .CLK_FREQ   (100_000_000),
    .DATA_WIDTH (8),
    .OVERSAMPLE (16)
  ) dut (
    .ACLK         (ACLK),
    .ARESET       (ARESET),
    .BAUD_RATE    (BAUD_RATE),
    .UART_RX      (UART_RX),
    .RX_DATA      (RX_DATA),
    .RX_DONE      (RX_DONE),
    .RX_FRAME_ERR (RX_FRAME_ERR),
    .RX_BUSY      (RX_BUSY),
    .DIV_VALID    (DIV_VALID)
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         when;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [7:0] last_good = 8'h00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest expected entry
  always @(negedge ACLK) begin
    if (RX_DONE === 1'b1 || RX_FRAME_ERR === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_strobe: done=%b err=%b data=%h cycle %0d",
                 RX_DONE, RX_FRAME_ERR, RX_DATA, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("strobe_kind", {62'd0, RX_DONE, RX_FRAME_ERR}, mon_e.is_err ? 64'd1 : 64'd2);
        check("rx_data", {56'd0, RX_DATA}, {56'd0, mon_e.data});
        check("strobe_time", 64'(cyc), 64'(mon_e.when));
      end
    end
  end

  // Caller must be at a negedge; leaves the line high at a negedge
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int bitc,
                            input int stop_len, input int div, input bit is_err);
    exp_t e;
    UART_RX  = 1'b0;
    e.is_err = is_err;
    e.data   = is_err ? last_good : d;
    e.when   = cyc + 3 + 152 * div;
    sb.push_back(e);
    if (!is_err) last_good = d;
    repeat (bitc) @(negedge ACLK);
    for (int i = 0; i < 8; i++) begin
      UART_RX = d[i];
      repeat (bitc) @(negedge ACLK);
    end
    UART_RX = stop_bit;
    repeat (stop_len) @(negedge ACLK);
    UART_RX = 1'b1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge ACLK);
      n++;
    end while (!DIV_VALID && n < 200);
    if (!DIV_VALID) n = -1;
  endtask

  initial begin
    int n;
    int busy_cnt;

    // Reset state and divisor latency at 9600 baud
    repeat (3) @(negedge ACLK);
    check("reset_rx_data", {56'd0, RX_DATA}, 64'd0);
    check("reset_done", {63'd0, RX_DONE}, 64'd0);
    check("reset_err", {63'd0, RX_FRAME_ERR}, 64'd0);
    check("reset_busy", {63'd0, RX_BUSY}, 64'd0);
    check("reset_div_valid", {63'd0, DIV_VALID}, 64'd0);
    ARESET = 1'b0;
    wait_valid(n);
    check("div_valid_latency_9600", 64'(n), 64'd34);

    // A short low pulse holds BUSY for half a bit: 8 ticks * 651 = 5208
    repeat (5) @(negedge ACLK);
    UART_RX  = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 6000; i++) begin
      if (i == 100) UART_RX = 1'b1;
      @(negedge ACLK);
      if (RX_BUSY) busy_cnt++;
    end
    check("half_bit_cycles_9600", 64'(busy_cnt), 64'd5208);

    // Divisor 1: back-to-back frames
    BAUD_RATE = 32'd6_250_000;
    wait_valid(n);
    check("div_valid_latency_6M25", 64'(n), 64'd34);
    repeat (5) @(negedge ACLK);
    send_frame(8'hA5, 1'b1, 16, 16, 1, 1'b0);
    send_frame(8'h3C, 1'b1, 16, 16, 1, 1'b0);
    repeat (20) @(negedge ACLK);

    // Start-bit glitch
    UART_RX = 1'b0;
    repeat (4) @(negedge ACLK);
    check("glitch_busy_high", {63'd0, RX_BUSY}, 64'd1);
    UART_RX = 1'b1;
    repeat (12) @(negedge ACLK);
    check("glitch_busy_low", {63'd0, RX_BUSY}, 64'd0);
    repeat (10) @(negedge ACLK);

    // Framing error with a long break, then a good frame
    send_frame(8'h5A, 1'b0, 16, 100, 1, 1'b1);
    repeat (20) @(negedge ACLK);
    send_frame(8'h77, 1'b1, 16, 16, 1, 1'b0);
    repeat (10) @(negedge ACLK);

    // Baud change in the middle of the data bits
    UART_RX = 1'b0;
    repeat (16) @(negedge ACLK);
    UART_RX = 1'b1;
    repeat (24) @(negedge ACLK);
    check("midframe_busy", {63'd0, RX_BUSY}, 64'd1);
    BAUD_RATE = 32'd3_125_000;
    n = 0;
    do begin
      @(negedge ACLK);
      if (!DIV_VALID) n++;
    end while (!DIV_VALID && n < 200);
    check("div_valid_low_cycles", 64'(n), 64'd33);
    check("busy_after_rebaud", {63'd0, RX_BUSY}, 64'd0);
    repeat (10) @(negedge ACLK);
    send_frame(8'hC3, 1'b1, 32, 32, 2, 1'b0);
    repeat (10) @(negedge ACLK);

    // Asynchronous reset during DATA
    BAUD_RATE = 32'd6_250_000;
    wait_valid(n);
    check("div_valid_latency_back", 64'(n), 64'd34);
    repeat (5) @(negedge ACLK);
    UART_RX = 1'b0;
    repeat (16) @(negedge ACLK);
    UART_RX = 1'b1;
    repeat (24) @(negedge ACLK);
    check("pre_reset_busy", {63'd0, RX_BUSY}, 64'd1);
    ARESET = 1'b1;
    #1;
    check("async_rx_data", {56'd0, RX_DATA}, 64'd0);
    check("async_done", {63'd0, RX_DONE}, 64'd0);
    check("async_err", {63'd0, RX_FRAME_ERR}, 64'd0);
    check("async_busy", {63'd0, RX_BUSY}, 64'd0);
    check("async_div_valid", {63'd0, DIV_VALID}, 64'd0);
    last_good = 8'h00;
    repeat (3) @(negedge ACLK);
    ARESET = 1'b0;
    wait_valid(n);
    check("div_valid_latency_reset", 64'(n), 64'd34);
    repeat (5) @(negedge ACLK);
    send_frame(8'h81, 1'b1, 16, 16, 1, 1'b0);
    repeat (200) @(negedge ACLK);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
